cla_accum_ctrl: RTL and testbench

- Sequencing stage wrapped around the 4-bit carry-lookahead adder.
- Accepts a stream of 4-bit two's-complement operands over a valid/ready handshake and drives the adder inputs with (accumulator, operand).
- Waits a programmable number of clock cycles for the adder's gate-delay ripple to settle, then captures its sum and signed-overflow outputs into a running accumulator.
- Also keeps a sticky overflow flag and an operation counter for the datapath above it.

---
 rtl/cla_accum_ctrl.sv | 137 +++++++++++++
 tb/tb_cla_accum_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_accum_ctrl.sv
// cla_accum_ctrl: sequencing stage around the 4-bit carry-lookahead adder.
// Holds adder inputs stable while the sum settles, then folds it into an accumulator.
`timescale 1ns/1ps
module cla_accum_ctrl #(
    parameter int WIDTH         = 4,
    parameter int SETTLE_CYCLES = 2,
    parameter int COUNT_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               clear,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    input  logic [WIDTH-1:0]   add_s,
    input  logic               add_o,
    output logic [WIDTH-1:0]   acc_out,
    output logic               acc_valid,
    output logic               ovf_sticky,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } state_e;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               clr_pend_q, clr_pend_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               ovf_q, ovf_d;
    logic [COUNT_W-1:0] ops_q, ops_d;
    logic               vld_q, vld_d;

    assign in_ready   = (state_q == IDLE) & ~reset;
    assign add_a      = a_q;
    assign add_b      = b_q;
    assign acc_out    = acc_q;
    assign acc_valid  = vld_q;
    assign ovf_sticky = ovf_q;
    assign op_count   = ops_q;

    // Next-state and datapath update for the accept / settle / capture sequence
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_pend_d = clr_pend_q;
        acc_d      = acc_q;
        a_d        = a_q;
        b_d        = b_q;
        ovf_d      = ovf_q;
        ops_d      = ops_q;
        vld_d      = 1'b0;

        unique case (state_q)
            IDLE: begin
                b_d = '0;
                if (clear) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    ops_d = '0;
                end else if (in_valid && in_ready) begin
                    b_d     = in_data;
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (clear) begin
                    clr_pend_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            CAPTURE: begin
                if (clr_pend_q || clear) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    ops_d = '0;
                end else begin
                    acc_d = add_s;
                    ovf_d = ovf_q | add_o;
                    ops_d = ops_q + COUNT_W'(1);
                    vld_d = 1'b1;
                end
                b_d        = '0;
                clr_pend_d = 1'b0;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Operand A tracks the accumulator except while the adder settles.
        if (state_q != SETTLE) begin
            a_d = acc_d;
        end
    end

    // State and datapath registers, cleared asynchronously on reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_pend_q <= 1'b0;
            acc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            ovf_q      <= 1'b0;
            ops_q      <= '0;
            vld_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_pend_q <= clr_pend_d;
            acc_q      <= acc_d;
            a_q        <= a_d;
            b_q        <= b_d;
            ovf_q      <= ovf_d;
            ops_q      <= ops_d;
            vld_q      <= vld_d;
        end
    end

endmodule

// File: tb/tb_cla_accum_ctrl.sv
// tb_cla_accum_ctrl: directed and random operand stream against an
// arithmetic reference model of the accumulator.
`timescale 1ns/1ps
module tb_cla_accum_ctrl;

    localparam int SC = 2;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       clear;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] add_s;
    logic       add_o;
    logic [3:0] acc_out;
    logic       acc_valid;
    logic       ovf_sticky;
    logic [3:0] op_count;

    int errors = 0;
    int checks = 0;

    logic [3:0] acc_m;
    logic       ovf_m;
    logic [3:0] cnt_m;

    int s_ab;

    cla_accum_ctrl #(.WIDTH(4), .SETTLE_CYCLES(SC), .COUNT_W(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .clear      (clear),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_s      (add_s),
        .add_o      (add_o),
        .acc_out    (acc_out),
        .acc_valid  (acc_valid),
        .ovf_sticky (ovf_sticky),
        .op_count   (op_count)
    );

    // Behavioural adder: modulo sum plus signed overflow from the true sum.
    assign add_s = add_a + add_b;
    assign s_ab  = int'($signed(add_a)) + int'($signed(add_b));
    assign add_o = (s_ab > 7) || (s_ab < -8);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_add(input logic [3:0] d);
        int s;
        s = int'($signed(acc_m)) + int'($signed(d));
        if (s > 7 || s < -8) ovf_m = 1'b1;
        acc_m = acc_m + d;
        cnt_m = cnt_m + 4'd1;
    endtask

    task automatic model_clear();
        acc_m = 4'd0;
        ovf_m = 1'b0;
        cnt_m = 4'd0;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_acc"}, acc_out, acc_m);
        chk({tag, "_ovf"}, ovf_sticky, ovf_m);
        chk({tag, "_cnt"}, op_count, cnt_m);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_acc"}, acc_out, 0);
        chk({tag, "_a"}, add_a, 0);
        chk({tag, "_b"}, add_b, 0);
        chk({tag, "_ovf"}, ovf_sticky, 0);
        chk({tag, "_cnt"}, op_count, 0);
        chk({tag, "_vld"}, acc_valid, 0);
        chk({tag, "_rdy"}, in_ready, 0);
    endtask

    // Called at a negedge with the block idle; returns at the negedge
    // where acc_valid is seen.
    task automatic add_op(input logic [3:0] d);
        int n;
        chk("ready_pre", in_ready, 1);
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 4'($urandom);
        chk("hold_a", add_a, acc_m);
        chk("hold_b", add_b, d);
        chk("busy", in_ready, 0);
        n = 0;
        while (acc_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, SC + 1);
        model_add(d);
        chk("ready_post", in_ready, 1);
        chk_state("add");
    endtask

    task automatic clear_idle();
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        model_clear();
        chk_state("clr");
        chk("clr_vld", acc_valid, 0);
    endtask

    initial begin
        int acc_n;
        int vld_n;
        logic seen;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 4'd0;
        clear    = 1'b0;
        model_clear();
        #1;
        chk_reset_outs("rst0");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rel_rdy", in_ready, 1);
        @(negedge clk);

        // 3 then 2
        add_op(4'h3);
        add_op(4'h2);
        chk("five", acc_out, 4'h5);

        // signed overflow, then sticky hold
        add_op(4'h4);
        chk("ovf_set", ovf_sticky, 1);
        add_op(4'h1);
        chk("ten", acc_out, 4'hA);

        // -1 + -1 is no overflow
        clear_idle();
        add_op(4'hF);
        add_op(4'hF);
        chk("fe", acc_out, 4'hE);

        // in_valid held high: one accept per SC+2 cycles
        acc_n    = 0;
        vld_n    = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_data = 4'($urandom);
            if (in_ready) begin
                acc_n++;
                model_add(in_data);
            end
            @(posedge clk);
            @(negedge clk);
            if (acc_valid) vld_n++;
        end
        in_valid = 1'b0;
        chk("stream_acc", acc_n, 3);
        chk("stream_vld", vld_n, 3);
        chk_state("stream");

        // clear during SETTLE discards the add
        clear_idle();
        add_op(4'h7);
        add_op(4'h1);
        add_op(4'hD);
        chk("pre_clr", acc_out, 4'h5);
        in_valid = 1'b1;
        in_data  = 4'h3;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        seen  = 1'b0;
        repeat (5) begin
            if (acc_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("clr_settle_vld", seen, 0);
        model_clear();
        chk_state("clr_settle");
        chk("clr_settle_rdy", in_ready, 1);

        // clear with in_valid in IDLE: no accept
        add_op(4'h2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h3;
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        model_clear();
        chk_state("clr_acc");
        chk("clr_acc_rdy", in_ready, 1);
        chk("clr_acc_b", add_b, 0);

        // 16 adds of 1 from reset: counter wraps
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        for (int i = 0; i < 16; i++) add_op(4'h1);
        chk("wrap_cnt", op_count, 0);
        chk("wrap_acc", acc_out, 0);
        chk("wrap_ovf", ovf_sticky, 1);

        // random operands with occasional clears
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(7) == 0) clear_idle();
            else add_op(4'($urandom));
        end

        // async reset mid-SETTLE
        add_op(4'h5);
        in_valid = 1'b1;
        in_data  = 4'h6;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        chk_reset_outs("rst_mid");
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #1;
        chk("rst_mid_rdy", in_ready, 1);
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (acc_valid) seen = 1'b1;
        end
        chk("rst_mid_vld", seen, 0);
        chk_state("rst_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
